// File: rtl/byte_block_packer.sv
// Packs a stream of bytes into BYTES-wide words, first byte in the MSB lane.
// A word is held until the consumer takes it. abort drops the current frame.
module byte_block_packer #(
  parameter  int BYTES = 4,
  localparam int CW    = $clog2(BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [8*BYTES-1:0] out_data,
  input  logic               out_ready,
  output logic [CW-1:0]      byte_cnt,
  output logic [7:0]         word_cnt
);

  localparam int          W    = 8 * BYTES;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state_r;
  logic [W-1:0]    hold_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      wcnt_r;
  logic            in_fire_s;
  logic            out_fire_s;

  assign out_data = hold_r;
  assign byte_cnt = cnt_r;
  assign word_cnt = wcnt_r;

  // Handshake qualifiers; in FULL the upstream is only let in when the word leaves.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst || abort) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          in_ready  = 1'b1;
          out_valid = 1'b0;
        end
        FULL: begin
          in_ready  = out_ready;
          out_valid = 1'b1;
        end
        default: begin
          in_ready  = 1'b0;
          out_valid = 1'b0;
        end
      endcase
    end
  end

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Packing state machine, word counter and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
      hold_r  <= '0;
      cnt_r   <= '0;
      wcnt_r  <= 8'd0;
    end else if (abort) begin
      state_r <= FILL;
      hold_r  <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        FILL: begin
          if (in_fire_s) begin
            hold_r <= {hold_r[W-9:0], in_data};
            cnt_r  <= cnt_r + CW'(1);
            if (cnt_r == LAST) begin
              state_r <= FULL;
            end
          end
        end
        FULL: begin
          if (out_fire_s) begin
            wcnt_r  <= wcnt_r + 8'd1;
            state_r <= FILL;
            // A byte arriving with the handshake starts the next word.
            if (in_fire_s) begin
              hold_r <= {{(W-8){1'b0}}, in_data};
              cnt_r  <= CW'(1);
            end else begin
              hold_r <= '0;
              cnt_r  <= '0;
            end
          end
        end
        default: begin
          state_r <= FILL;
          hold_r  <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_block_packer.sv
// Bench for byte_block_packer: directed frames plus a random phase, with a
// packing model feeding a word queue that a separate monitor drains.
module tb_byte_block_packer;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [2:0]   byte_cnt;
  logic [7:0]   word_cnt;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mhold = '0;
  int           mcnt = 0;
  logic [7:0]   mwc = 8'd0;

  byte_block_packer #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .byte_cnt(byte_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
  endtask

  // Reference model: checks handshake outputs, then advances over the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
      check("rst_word_cnt", 64'(word_cnt), 64'd0);
      if (mcnt == BYTES && exp_q.size() > 0) void'(exp_q.pop_back());
      mcnt  = 0;
      mhold = '0;
      mwc   = 8'd0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!abort && (mcnt < BYTES || out_ready)));
      check("out_valid", 64'(out_valid), 64'(!abort && mcnt == BYTES));
      check("byte_cnt", 64'(byte_cnt), 64'(mcnt));
      check("word_cnt", 64'(word_cnt), 64'(mwc));
      if (abort) begin
        if (mcnt == BYTES && exp_q.size() > 0) void'(exp_q.pop_back());
        mcnt  = 0;
        mhold = '0;
      end else if (mcnt < BYTES) begin
        if (in_valid) begin
          mhold = {mhold[W-9:0], in_data};
          mcnt++;
          if (mcnt == BYTES) exp_q.push_back(mhold);
        end
      end else if (out_ready) begin
        mwc = mwc + 8'd1;
        if (in_valid) begin
          mhold = {{(W-8){1'b0}}, in_data};
          mcnt  = 1;
        end else begin
          mhold = '0;
          mcnt  = 0;
        end
      end
    end
  end

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("out_word", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_ready_async", 64'(in_ready), 64'd0);
    step(); step(); step();
    rst = 1'b0;
    settle();
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // Single word with consumer ready.
    out_ready = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    in_valid = 1'b0;
    settle();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'h1122_3344);
    step(); settle();
    check("t1_word_cnt", 64'(word_cnt), 64'd1);
    check("t1_valid_drop", 64'(out_valid), 64'd0);

    // Backpressure in FULL, then handshake with a simultaneous byte.
    out_ready = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t2_hold_data", 64'(out_data), 64'h1122_3344);
      check("t2_ready_low", 64'(in_ready), 64'd0);
      check("t2_cnt_full", 64'(byte_cnt), 64'd4);
      step();
    end
    out_ready = 1'b1;
    settle();
    check("t2_ready_follows", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    settle();
    check("t2_cnt_one", 64'(byte_cnt), 64'd1);
    check("t2_word_cnt", 64'(word_cnt), 64'd2);
    check("t2_captured", 64'(out_data), 64'h0000_0055);
    send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    in_valid = 1'b0;
    settle();
    check("t2_second", 64'(out_data), 64'h5566_7788);
    step();

    // Continuous streaming, 8 words.
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      settle();
      check("t3_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    step(); settle();
    check("t3_word_cnt", 64'(word_cnt), 64'd11);

    // Abort mid-frame, then abort while FULL.
    send_byte(8'hAA); send_byte(8'hBB);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    settle();
    check("t4_abort_ready", 64'(in_ready), 64'd0);
    check("t4_abort_valid", 64'(out_valid), 64'd0);
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    settle();
    check("t4_cnt_cleared", 64'(byte_cnt), 64'd0);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    in_valid = 1'b0;
    settle();
    check("t4_word", 64'(out_data), 64'h0102_0304);
    step(); settle();
    check("t4_word_cnt", 64'(word_cnt), 64'd12);
    out_ready = 1'b0;
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23); send_byte(8'h24);
    in_valid = 1'b0;
    settle();
    check("t4_full_valid", 64'(out_valid), 64'd1);
    abort     = 1'b1;
    out_ready = 1'b1;
    settle();
    check("t4_full_abort_valid", 64'(out_valid), 64'd0);
    step();
    abort = 1'b0;
    settle();
    check("t4_wc_unchanged", 64'(word_cnt), 64'd12);
    check("t4_cnt_zero", 64'(byte_cnt), 64'd0);

    // 256 words wrap the word counter.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    settle();
    check("t5_wc_reset", 64'(word_cnt), 64'd0);
    for (int w = 0; w < 256; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        send_byte(8'(w * BYTES + b));
      end
    end
    in_valid = 1'b0;
    settle();
    check("t5_wc_255", 64'(word_cnt), 64'd255);
    step(); settle();
    check("t5_wc_wrap", 64'(word_cnt), 64'd0);

    // Reset mid-frame clears outputs without waiting for a clock edge.
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    in_valid = 1'b0;
    settle();
    check("t5_cnt3", 64'(byte_cnt), 64'd3);
    rst = 1'b1;
    #1;
    check("t5_async_cnt", 64'(byte_cnt), 64'd0);
    check("t5_async_data", 64'(out_data), 64'd0);
    check("t5_async_ready", 64'(in_ready), 64'd0);
    check("t5_async_valid", 64'(out_valid), 64'd0);
    check("t5_async_wc", 64'(word_cnt), 64'd0);
    step(); step();
    rst = 1'b0;
    settle();
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    in_valid = 1'b0;
    settle();
    check("t5_after_rst", 64'(out_data), 64'hDEAD_BEEF);
    step();

    // Random handshakes; the monitor checks every word against the model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
